axi_decim_avg: RTL and testbench
================================

# axi_decim_avg

Power-of-two boxcar decimator sitting on the user-IP side of the CHDR wrapper. It consumes the 32-bit sample stream and 128-bit header tuser from the wrapper's deframer output (`m_axis_data_*`). It produces averaged samples at 1/2^k rate, with packet-aligned tlast, back into the wrapper's framer input (`s_axis_data_*`). The wrapper then rebuilds packet length and corrects VITA time for the rate change.

## Interface
Parameters:
- `SR_DECIM`, 129: settings-bus address of the decimation register.
- `MAX_LOG2`, 8: largest allowed k (decimation up to 2^MAX_LOG2); range 1..15.

Ports:
- `clk`  in  1  sole clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high.
- `clear`  in  1  synchronous soft clear; same effect as reset except the k register is kept.
- `set_stb`  in  1  settings write strobe.
- `set_addr`  in  8  settings address.
- `set_data`  in  32  settings data; [3:0] = k.
- `i_tdata`  in  32  sample: [31:16] I, [15:0] Q, two's complement.
- `i_tuser`  in  128  CHDR header of the current input packet.
- `i_tlast`  in  1  last sample of input packet.
- `i_tvalid`  in  1  input valid.
- `i_tready`  out  1  input ready.
- `o_tdata`  out  32  averaged sample, same I/Q format.
- `o_tuser`  out  128  header latched at the first sample of the input packet.
- `o_tlast`  out  1  last output of packet.
- `o_tvalid`  out  1  output valid.
- `o_tready`  in  1  output ready.

## Operation
- Register `k` (4 bits):
  - Written when `set_stb && set_addr==SR_DECIM`.
  - Values above MAX_LOG2 clamp to MAX_LOG2.
  - Reset value 0 (pass-through: N = 1).
- A write to `k` also zeroes the accumulators and the sample counter, discarding any partial block. In-flight output-register contents are preserved.
- Two signed accumulators (I, Q), each 16+MAX_LOG2 bits, sign-extended adds. Counter `cnt` is MAX_LOG2 bits wide.
- On each input handshake:
  - Add the sample into `acc`.
  - If `cnt == 2^k-1` or `i_tlast`: emit `(acc+sample) >>> k` (arithmetic shift, low 16 bits per component) into the output register, then clear `acc` and `cnt`.
  - Otherwise increment `cnt`.
- Partial block at `i_tlast`: emitted, still scaled by `>>> k`. Output packets always align to input packets.
- `o_tlast` = `i_tlast` of the sample that closed the block.
- Header latch:
  - A start-of-packet flag sets after reset, after clear, and after any handshake with `i_tlast`.
  - On the first handshake of a packet, `i_tuser` is latched into the header register.
  - `o_tuser` is taken from that header register, copied into the output register alongside the data.
  - The length and time fields are not modified.
- k = 0: every input sample is emitted unchanged, with its tlast.

## Timing
- Output stage is a single register. `i_tready = ~o_tvalid | o_tready` (combinational from `o_tready`).
- Stall cost: non-closing samples are also stalled while the output register is full and `o_tready` is low. This is accepted; it adds no bubble when downstream is ready.
- Latency: 1 cycle from the closing input handshake to `o_tvalid` high.
- Throughput: 1 input sample per cycle sustained.
- `o_tvalid` deasserts on output handshake unless a new closing sample is handshaken in the same cycle; in that case the register reloads and stays valid.
- Output stability: `o_tdata`, `o_tuser` and `o_tlast` hold stable while `o_tvalid && !o_tready`.
- Reset/clear outputs: `o_tvalid` 0, `o_tdata` 0, `o_tuser` 0, `o_tlast` 0, `i_tready` 1; accumulators, counter and header cleared. Reset additionally sets k = 0.
- Reset mid-block: the partial block is dropped with no output.
- Settings write coinciding with an input handshake: the write wins. The sample is discarded and the new k applies from the next cycle.
- Full-scale input (all samples -32768) averages to -32768 with no overflow; the accumulator width guarantees this.

## Configuration
- `DECIM_AVG_ROUND_EN` defined:
  - When k>0, add `2^(k-1)` to the sum before the shift (round half up).
  - No saturation is needed: for 32767 inputs the rounded sum still shifts back to ≤ 32767.
- Undefined: plain arithmetic shift (floor); the adder is removed.

## Test plan
- k=0, 8-sample packet, I=Q=n → identical 8 outputs; tlast on 8th; `o_tuser` equals input header.
- k=2, 16-sample packet of I=4, Q=-4 → 4 outputs I=4, Q=-4; tlast only on 4th; one output every 4 inputs with 1-cycle latency.
- k=1, samples I=1 then I=2 → I=1 without `DECIM_AVG_ROUND_EN`, I=2 with it.
- k=2, 6-sample packet (I=8 each) then new packet with a different header → outputs I=8 and a partial I=4 with tlast. The next packet's output carries the new header.
- k=3, `o_tready` toggled 1/0 every cycle with random `i_tvalid` → output sequence matches the golden model; no loss or duplication; data held stable while stalled.
- Settings write k=3 after 5 samples of a block, then reset asserted mid-block → partial blocks discarded, no output, `o_tvalid`=0 the cycle after reset.

Source files
------------

// File: rtl/axi_decim_avg.sv
// Power-of-two boxcar decimator for the CHDR user-IP stream: averages 2^k I/Q samples
// per output with packet-aligned tlast. Define DECIM_AVG_ROUND_EN for round-half-up.
module axi_decim_avg #(
  parameter int SR_DECIM = 129,
  parameter int MAX_LOG2 = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         set_stb,
  input  logic [7:0]   set_addr,
  input  logic [31:0]  set_data,
  input  logic [31:0]  i_tdata,
  input  logic [127:0] i_tuser,
  input  logic         i_tlast,
  input  logic         i_tvalid,
  output logic         i_tready,
  output logic [31:0]  o_tdata,
  output logic [127:0] o_tuser,
  output logic         o_tlast,
  output logic         o_tvalid,
  input  logic         o_tready
);

  localparam int AW = 16 + MAX_LOG2;
  localparam int CW = MAX_LOG2;
  localparam logic [7:0] SR_ADDR = 8'(SR_DECIM);
  localparam logic [3:0] K_MAX = 4'(MAX_LOG2);

  logic [3:0]           k_q, k_d;
  logic signed [AW-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sop_q, sop_d;
  logic [127:0]         hdr_q, hdr_d;
  logic [31:0]          o_tdata_q, o_tdata_d;
  logic [127:0]         o_tuser_q, o_tuser_d;
  logic                 o_tlast_q, o_tlast_d;
  logic                 o_tvalid_q, o_tvalid_d;

  logic                 in_hs, out_hs, set_wr, blk_close;
  logic [3:0]           k_wr;
  logic [CW:0]          blk_last;
  logic signed [AW-1:0] samp_i, samp_q, sum_i, sum_q, rnd, shr_i, shr_q;
  logic [127:0]         cur_hdr;
  logic                 unused_bits;

  assign i_tready = ~o_tvalid_q | o_tready;
  assign o_tdata  = o_tdata_q;
  assign o_tuser  = o_tuser_q;
  assign o_tlast  = o_tlast_q;
  assign o_tvalid = o_tvalid_q;

  assign in_hs  = i_tvalid & i_tready;
  assign out_hs = o_tvalid_q & o_tready;
  assign set_wr = set_stb & (set_addr == SR_ADDR);
  assign k_wr   = (set_data[3:0] > K_MAX) ? K_MAX : set_data[3:0];

  // k never exceeds MAX_LOG2, so 2^k-1 always fits in CW+1 bits.
  assign blk_last  = ({{CW{1'b0}}, 1'b1} << k_q) - {{CW{1'b0}}, 1'b1};
  assign blk_close = ({1'b0, cnt_q} == blk_last) | i_tlast;

  assign samp_i = {{MAX_LOG2{i_tdata[31]}}, i_tdata[31:16]};
  assign samp_q = {{MAX_LOG2{i_tdata[15]}}, i_tdata[15:0]};
  assign sum_i  = acc_i_q + samp_i;
  assign sum_q  = acc_q_q + samp_q;

`ifdef DECIM_AVG_ROUND_EN
  assign rnd = ({{(AW-1){1'b0}}, 1'b1} << k_q) >> 1;
`else
  assign rnd = '0;
`endif

  assign shr_i = (sum_i + rnd) >>> k_q;
  assign shr_q = (sum_q + rnd) >>> k_q;

  // A block closed by the packet's first sample must carry that sample's header.
  assign cur_hdr = sop_q ? i_tuser : hdr_q;

  assign unused_bits = ^{set_data[31:4], shr_i[AW-1:16], shr_q[AW-1:16]};

  always_comb begin
    k_d        = k_q;
    acc_i_d    = acc_i_q;
    acc_q_d    = acc_q_q;
    cnt_d      = cnt_q;
    sop_d      = sop_q;
    hdr_d      = hdr_q;
    o_tdata_d  = o_tdata_q;
    o_tuser_d  = o_tuser_q;
    o_tlast_d  = o_tlast_q;
    o_tvalid_d = o_tvalid_q;

    if (out_hs) o_tvalid_d = 1'b0;

    // A settings write drops any partial block and any sample arriving with it.
    if (set_wr) begin
      k_d     = k_wr;
      acc_i_d = '0;
      acc_q_d = '0;
      cnt_d   = '0;
    end else if (in_hs) begin
      if (sop_q) hdr_d = i_tuser;
      sop_d = i_tlast;
      if (blk_close) begin
        o_tdata_d  = {shr_i[15:0], shr_q[15:0]};
        o_tuser_d  = cur_hdr;
        o_tlast_d  = i_tlast;
        o_tvalid_d = 1'b1;
        acc_i_d    = '0;
        acc_q_d    = '0;
        cnt_d      = '0;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      k_q        <= reset ? 4'd0 : k_q;
      acc_i_q    <= '0;
      acc_q_q    <= '0;
      cnt_q      <= '0;
      sop_q      <= 1'b1;
      hdr_q      <= '0;
      o_tdata_q  <= '0;
      o_tuser_q  <= '0;
      o_tlast_q  <= 1'b0;
      o_tvalid_q <= 1'b0;
    end else begin
      k_q        <= k_d;
      acc_i_q    <= acc_i_d;
      acc_q_q    <= acc_q_d;
      cnt_q      <= cnt_d;
      sop_q      <= sop_d;
      hdr_q      <= hdr_d;
      o_tdata_q  <= o_tdata_d;
      o_tuser_q  <= o_tuser_d;
      o_tlast_q  <= o_tlast_d;
      o_tvalid_q <= o_tvalid_d;
    end
  end

endmodule

// File: tb/tb_axi_decim_avg.sv
// Directed-vector bench for axi_decim_avg: table of streamed samples with expected
// outputs, plus hand sequences for settings, clear, reset and backpressure.
module tb_axi_decim_avg;

`ifdef DECIM_AVG_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  localparam logic [127:0] H1   = {4{32'h1111_0001}};
  localparam logic [127:0] H2   = {4{32'h2222_0002}};
  localparam logic [127:0] H3   = {4{32'h3333_0003}};
  localparam logic [127:0] H4   = {4{32'h4444_0004}};
  localparam logic [127:0] H5   = {4{32'h5555_0005}};
  localparam logic [127:0] H6   = {4{32'h6666_0006}};
  localparam logic [127:0] H7   = {4{32'h7777_0007}};
  localparam logic [127:0] JUNK = {4{32'hDEAD_BEEF}};
  localparam int NRAND = 60;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         set_stb = 1'b0;
  logic [7:0]   set_addr = 8'd0;
  logic [31:0]  set_data = 32'd0;
  logic [31:0]  i_tdata = 32'd0;
  logic [127:0] i_tuser = '0;
  logic         i_tlast = 1'b0;
  logic         i_tvalid = 1'b0;
  logic         i_tready;
  logic [31:0]  o_tdata;
  logic [127:0] o_tuser;
  logic         o_tlast;
  logic         o_tvalid;
  logic         o_tready = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int           k;
    logic [31:0]  d;
    logic         l;
    logic [127:0] u;
    logic         ev;
    logic [31:0]  ed;
    logic         el;
    logic [127:0] eu;
  } vec_t;

  vec_t tbl[$];
  logic [32:0] exp_q[$];

  axi_decim_avg dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
    .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_k(input int v);
    set_stb  = 1'b1;
    set_addr = 8'd129;
    set_data = 32'(v);
    cyc();
    set_stb  = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [127:0] u);
    i_tvalid = 1'b1;
    i_tdata  = d;
    i_tlast  = l;
    i_tuser  = u;
    cyc();
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  function automatic void add(input int k, input logic [31:0] d, input logic l,
                              input logic [127:0] u, input logic ev,
                              input logic [31:0] ed, input logic el, input logic [127:0] eu);
    vec_t v;
    v.k = k; v.d = d; v.l = l; v.u = u; v.ev = ev; v.ed = ed; v.el = el; v.eu = eu;
    tbl.push_back(v);
  endfunction

  initial begin
    int cur_k;
    int vcnt;
    int sent;
    int cyc_n;
    int m_cnt;
    int acc_i, acc_q, ri, rq;
    bit prev_stall;
    bit took;
    logic [32:0] held;
    logic [32:0] e;
    logic signed [15:0] si, sq;
    logic [31:0] rd[NRAND];
    logic        rl[NRAND];

    // k=0 pass-through; only the first sample carries the real header
    for (int n = 1; n <= 8; n++)
      add(0, {16'(n), 16'(n)}, n == 8, (n == 1) ? H1 : JUNK, 1'b1, {16'(n), 16'(n)}, n == 8, H1);
    // k=2, I=4 Q=-4: one output per four inputs
    for (int n = 0; n < 16; n++)
      add(2, 32'h0004_FFFC, n == 15, (n == 0) ? H4 : JUNK, (n % 4) == 3, 32'h0004_FFFC, n == 15, H4);
    // k=1 floor vs round-half-up, positive then negative
    add(1, 32'h0001_0000, 1'b0, H5, 1'b0, 32'h0, 1'b0, H5);
    add(1, 32'h0002_0000, 1'b1, JUNK, 1'b1, RND ? 32'h0002_0000 : 32'h0001_0000, 1'b1, H5);
    add(1, 32'hFFFF_0000, 1'b0, H6, 1'b0, 32'h0, 1'b0, H6);
    add(1, 32'hFFFE_0000, 1'b1, JUNK, 1'b1, RND ? 32'hFFFF_0000 : 32'hFFFE_0000, 1'b1, H6);
    // k=2, 6-sample packet: one full block then a partial one, then a new header
    for (int n = 0; n < 6; n++)
      add(2, 32'h0008_0000, n == 5, (n == 0) ? H2 : JUNK, n == 3 || n == 5,
          (n == 5) ? 32'h0004_0000 : 32'h0008_0000, n == 5, H2);
    for (int n = 0; n < 4; n++)
      add(2, 32'h0008_0000, n == 3, (n == 0) ? H3 : JUNK, n == 3, 32'h0008_0000, 1'b1, H3);

    for (int i = 0; i < NRAND; i++) begin
      rd[i] = $urandom();
      rl[i] = (i == NRAND - 1) || ($urandom_range(0, 6) == 0);
    end

    // reset state
    cyc();
    cyc();
    chk("rst_tvalid", 128'(o_tvalid), 128'd0);
    chk("rst_tdata", 128'(o_tdata), 128'd0);
    chk("rst_tuser", o_tuser, 128'd0);
    chk("rst_tlast", 128'(o_tlast), 128'd0);
    chk("rst_tready", 128'(i_tready), 128'd1);
    reset = 1'b0;
    cyc();

    // table-driven streaming with o_tready held high
    cur_k = -1;
    foreach (tbl[i]) begin
      if (tbl[i].k != cur_k) begin
        set_k(tbl[i].k);
        cur_k = tbl[i].k;
      end
      i_tvalid = 1'b1;
      i_tdata  = tbl[i].d;
      i_tlast  = tbl[i].l;
      i_tuser  = tbl[i].u;
      cyc();
      chk($sformatf("tbl%0d_valid", i), 128'(o_tvalid), 128'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), 128'(o_tdata), 128'(tbl[i].ed));
        chk($sformatf("tbl%0d_last", i), 128'(o_tlast), 128'(tbl[i].el));
        chk($sformatf("tbl%0d_user", i), o_tuser, tbl[i].eu);
      end
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;

    // full scale with k written above MAX_LOG2 (clamps to 8 -> 256-sample block)
    set_k(15);
    vcnt = 0;
    for (int n = 0; n < 256; n++) begin
      send(32'h8000_7FFF, n == 255, (n == 0) ? H7 : JUNK);
      if (o_tvalid) vcnt++;
    end
    chk("fs_count", 128'(vcnt), 128'd1);
    chk("fs_data", 128'(o_tdata), 128'h8000_7FFF);
    chk("fs_last", 128'(o_tlast), 128'd1);
    chk("fs_user", o_tuser, H7);

    // settings write coinciding with a handshake drops the partial block and the sample
    set_k(1);
    send(32'h0010_0000, 1'b0, H1);
    set_stb  = 1'b1;
    set_addr = 8'd129;
    set_data = 32'd1;
    send(32'h0100_0000, 1'b0, JUNK);
    set_stb  = 1'b0;
    chk("wr_drop_valid", 128'(o_tvalid), 128'd0);
    send(32'h0002_0000, 1'b0, JUNK);
    send(32'h0004_0000, 1'b1, JUNK);
    chk("wr_after_valid", 128'(o_tvalid), 128'd1);
    chk("wr_after_data", 128'(o_tdata), 128'h0003_0000);

    // clear zeroes outputs and partial sums but keeps k
    send(32'h0010_0000, 1'b0, H2);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_tvalid", 128'(o_tvalid), 128'd0);
    chk("clr_tdata", 128'(o_tdata), 128'd0);
    send(32'h0002_0000, 1'b0, H3);
    chk("clr_k_kept", 128'(o_tvalid), 128'd0);
    send(32'h0002_0000, 1'b1, JUNK);
    chk("clr_avg_data", 128'(o_tdata), 128'h0002_0000);
    chk("clr_avg_user", o_tuser, H3);

    // k=3 with o_tready toggling and random i_tvalid against an integer model
    set_k(3);
    i_tuser = H4;
    sent = 0; cyc_n = 0; m_cnt = 0; acc_i = 0; acc_q = 0;
    prev_stall = 1'b0; took = 1'b0; held = '0;
    o_tready = 1'b0;
    while (!(sent == NRAND && exp_q.size() == 0 && !o_tvalid) && cyc_n < 3000) begin
      @(posedge clk);
      #1;
      cyc_n++;
      o_tready = ~o_tready;
      if (sent < NRAND) begin
        if (!i_tvalid || took) i_tvalid = 1'($urandom_range(0, 1));
        i_tdata = rd[sent];
        i_tlast = rl[sent];
      end else begin
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
      end
      @(negedge clk);
      took = 1'b0;
      if (prev_stall)
        chk("rnd_stall_hold", {95'd0, o_tvalid, o_tlast, o_tdata}, {95'd0, 1'b1, held});
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_extra_output", 128'(exp_q.size()), 128'd1);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_out", 128'({o_tlast, o_tdata}), 128'(e));
        end
      end
      prev_stall = o_tvalid && !o_tready;
      held = {o_tlast, o_tdata};
      if (i_tvalid && i_tready) begin
        si = i_tdata[31:16];
        sq = i_tdata[15:0];
        acc_i += si;
        acc_q += sq;
        if (m_cnt == 7 || i_tlast) begin
          ri = (acc_i + (RND ? 4 : 0)) >>> 3;
          rq = (acc_q + (RND ? 4 : 0)) >>> 3;
          exp_q.push_back({i_tlast, ri[15:0], rq[15:0]});
          acc_i = 0; acc_q = 0; m_cnt = 0;
        end else begin
          m_cnt++;
        end
        sent++;
        took = 1'b1;
      end
    end
    chk("rnd_done_in_time", 128'(cyc_n < 3000), 128'd1);
    chk("rnd_all_sent", 128'(sent), 128'(NRAND));
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    o_tready = 1'b1;

    // k=3: partial block, rewrite k, partial again, then reset mid-block
    set_k(3);
    vcnt = 0;
    for (int n = 0; n < 5; n++) begin
      send(32'h0001_0001, 1'b0, H5);
      if (o_tvalid) vcnt++;
    end
    set_k(3);
    for (int n = 0; n < 3; n++) begin
      send(32'h0001_0001, 1'b0, H5);
      if (o_tvalid) vcnt++;
    end
    chk("mid_no_output", 128'(vcnt), 128'd0);
    reset = 1'b1;
    cyc();
    chk("mid_rst_tvalid", 128'(o_tvalid), 128'd0);
    reset = 1'b0;
    cyc();
    send(32'h1234_5678, 1'b1, H6);
    chk("post_rst_valid", 128'(o_tvalid), 128'd1);
    chk("post_rst_data", 128'(o_tdata), 128'h1234_5678);
    chk("post_rst_user", o_tuser, H6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
